// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its downstream decoder bench:
// opcode values, HALT prefix, FSM encoding and default geometry.
package instr_fetch_pkg;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 8;

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

    localparam logic [1:0] HALT_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    // OP_3 doubles as JUMP and HALT; the top two operand bits pick which.
    function automatic logic is_halt(input logic [1:0] opcode, input logic [1:0] prefix);
        return (opcode == OP_3) && (prefix == HALT_PREFIX);
    endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program store: 2^AW x DW register array, synchronous write, combinational read, no reset
// so a loaded program survives RST.
module prog_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing stage: steps PC through prog_mem, issues one opcode+operand per
// FETCH/ISSUE pair, and handles jump, halt, stall and start/stop.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [DW-1:0] LOAD_DATA,
    input  logic          START,
    input  logic          STALL,
    output logic [1:0]    INSTR,
    output logic [DW-3:0] OPERAND,
    output logic [AW-1:0] PC,
    output logic          VALID,
    output logic          BUSY,
    output logic          DONE
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          valid_q;
    logic          busy_q;
    logic          done_s;
    logic          mem_we_s;
    logic [DW-1:0] mem_rdata_s;
    logic [1:0]    opcode_s;
    logic [1:0]    prefix_s;

    assign mem_we_s = LOAD_EN && (state_q == ST_IDLE);
    assign opcode_s = ir_q[DW-1 -: 2];
    assign prefix_s = ir_q[DW-3 -: 2];

    prog_mem #(
        .AW (AW),
        .DW (DW)
    ) u_prog_mem (
        .clk_i   (CLK),
        .we_i    (mem_we_s),
        .waddr_i (LOAD_ADDR),
        .wdata_i (LOAD_DATA),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata_s)
    );

    // Next-state, PC/IR update and the HALT retire pulse
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A coincident load wins over START.
                if (START && !LOAD_EN) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_d    = mem_rdata_s;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (STALL) begin
                    state_d = ST_ISSUE;
                end else if (opcode_s != OP_3) begin
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    state_d = ST_FETCH;
                end else if (is_halt(opcode_s, prefix_s)) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    pc_d    = ir_q[AW-1:0];
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, IR and registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= (state_d == ST_ISSUE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign INSTR   = opcode_s;
    assign OPERAND = ir_q[DW-3:0];
    assign PC      = pc_q;
    assign VALID   = valid_q;
    assign BUSY    = busy_q;
    assign DONE    = done_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed cycle tables plus randomized programs
// checked against an instruction-level interpreter of the program memory.
module tb_instr_fetch;

    logic       CLK;
    logic       RST;
    logic       LOAD_EN;
    logic [3:0] LOAD_ADDR;
    logic [7:0] LOAD_DATA;
    logic       START;
    logic       STALL;
    logic [1:0] INSTR;
    logic [5:0] OPERAND;
    logic [3:0] PC;
    logic       VALID;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [16];
    int         trace [$];

    typedef struct {
        logic       start;
        logic       stall;
        logic       valid;
        logic       busy;
        logic       done;
        logic [1:0] instr;
        logic [5:0] operand;
        logic [3:0] pc;
    } vec_t;

    vec_t vq [$];

    instr_fetch #(.AW(4), .DW(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .LOAD_EN   (LOAD_EN),
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_DATA (LOAD_DATA),
        .START     (START),
        .STALL     (STALL),
        .INSTR     (INSTR),
        .OPERAND   (OPERAND),
        .PC        (PC),
        .VALID     (VALID),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sl, input logic v, input logic b, input logic d,
                       input logic [1:0] i, input logic [5:0] o, input logic [3:0] p);
        vec_t r;
        r.start = st; r.stall = sl; r.valid = v; r.busy = b; r.done = d;
        r.instr = i; r.operand = o; r.pc = p;
        vq.push_back(r);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [7:0] data);
        LOAD_EN = 1'b1; LOAD_ADDR = 4'(addr); LOAD_DATA = data;
        next_cycle();
        LOAD_EN = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(BUSY),    32'd0);
        check({tag, "_valid"},   32'(VALID),   32'd0);
        check({tag, "_done"},    32'(DONE),    32'd0);
        check({tag, "_pc"},      32'(PC),      32'd0);
        check({tag, "_instr"},   32'(INSTR),   32'd0);
        check({tag, "_operand"}, 32'(OPERAND), 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle: outputs must clear before any clock edge.
    task automatic apply_reset(input string tag);
        RST = 1'b1;
        #1;
        check_reset_outputs(tag);
        next_cycle();
        RST = 1'b0;
        START = 1'b0; LOAD_EN = 1'b0; STALL = 1'b0;
    endtask

    // mode 0: quiet, 1: random ignored START/LOAD/STALL, 2: START and LOAD 0<-FF every cycle
    task automatic drive_noise(input int mode);
        case (mode)
            1: begin
                START     = ($urandom_range(0, 3) == 0);
                LOAD_EN   = ($urandom_range(0, 3) == 0);
                LOAD_ADDR = 4'($urandom);
                LOAD_DATA = 8'($urandom);
                STALL     = 1'($urandom_range(0, 1));
            end
            2: begin
                START = 1'b1; LOAD_EN = 1'b1; LOAD_ADDR = 4'd0; LOAD_DATA = 8'hFF; STALL = 1'b0;
            end
            default: begin
                START = 1'b0; LOAD_EN = 1'b0; STALL = 1'b0;
            end
        endcase
    endtask

    // Interpret the program in ref_mem instruction by instruction and check each cycle.
    task automatic run_program(input string tag, input int max_issues, input int mode, output bit halted);
        int         pc;
        int         k;
        logic [7:0] w;
        bit         is_halt_w;
        halted = 1'b0;
        trace.delete();
        LOAD_EN = 1'b0; STALL = 1'b0; START = 1'b1;
        #1;
        check({tag, "_start_busy"}, 32'(BUSY), 32'd0);
        next_cycle();
        pc = 0;
        for (int n = 0; n < max_issues && !halted; n++) begin
            drive_noise(mode);
            #1;
            check($sformatf("%s_fetch%0d_valid", tag, n), 32'(VALID), 32'd0);
            check($sformatf("%s_fetch%0d_busy", tag, n), 32'(BUSY), 32'd1);
            check($sformatf("%s_fetch%0d_pc", tag, n), 32'(PC), 32'(pc));
            next_cycle();
            w = ref_mem[pc];
            is_halt_w = (w[7:6] == 2'b11) && (w[5:4] == 2'b11);
            k = (mode == 1) ? $urandom_range(0, 2) : 0;
            for (int j = 0; j <= k; j++) begin
                drive_noise(mode);
                STALL = (j < k);
                #1;
                check($sformatf("%s_issue%0d_valid", tag, n), 32'(VALID), 32'd1);
                check($sformatf("%s_issue%0d_instr", tag, n), 32'(INSTR), 32'(w[7:6]));
                check($sformatf("%s_issue%0d_operand", tag, n), 32'(OPERAND), 32'(w[5:0]));
                check($sformatf("%s_issue%0d_pc", tag, n), 32'(PC), 32'(pc));
                check($sformatf("%s_issue%0d_done", tag, n), 32'(DONE), 32'((j == k) && is_halt_w));
                next_cycle();
            end
            trace.push_back(pc);
            if (is_halt_w) halted = 1'b1;
            else if (w[7:6] == 2'b11) pc = int'(w[3:0]);
            else pc = (pc + 1) % 16;
        end
        drive_noise(0);
        if (halted) begin
            #1;
            check({tag, "_after_halt_busy"}, 32'(BUSY), 32'd0);
            check({tag, "_after_halt_valid"}, 32'(VALID), 32'd0);
            check({tag, "_after_halt_pc"}, 32'(PC), 32'(pc));
            next_cycle();
        end
    endtask

    initial begin
        bit halted;
        RST = 1'b1; LOAD_EN = 1'b0; LOAD_ADDR = 4'd0; LOAD_DATA = 8'd0; START = 1'b0; STALL = 1'b0;
        next_cycle();
        next_cycle();
        check_reset_outputs("reset");
        RST = 1'b0;
        next_cycle();
        check_reset_outputs("post_reset");

        // Basic program, then the same program with a 3-cycle stall on the first issue.
        load_word(0, 8'h05); load_word(1, 8'h4A); load_word(2, 8'h80); load_word(3, 8'hF0);
        add(1,0, 0,0,0, 2'd0,6'h00,4'd0);
        add(0,0, 0,1,0, 2'd0,6'h00,4'd0);
        add(0,0, 1,1,0, 2'd0,6'h05,4'd0);
        add(0,0, 0,1,0, 2'd0,6'h05,4'd1);
        add(0,0, 1,1,0, 2'd1,6'h0A,4'd1);
        add(0,0, 0,1,0, 2'd1,6'h0A,4'd2);
        add(0,0, 1,1,0, 2'd2,6'h00,4'd2);
        add(0,0, 0,1,0, 2'd2,6'h00,4'd3);
        add(0,0, 1,1,1, 2'd3,6'h30,4'd3);
        add(0,0, 0,0,0, 2'd3,6'h30,4'd3);
        add(1,0, 0,0,0, 2'd3,6'h30,4'd3);
        add(0,1, 0,1,0, 2'd3,6'h30,4'd0);
        add(0,1, 1,1,0, 2'd0,6'h05,4'd0);
        add(0,1, 1,1,0, 2'd0,6'h05,4'd0);
        add(0,1, 1,1,0, 2'd0,6'h05,4'd0);
        add(0,0, 1,1,0, 2'd0,6'h05,4'd0);
        add(0,0, 0,1,0, 2'd0,6'h05,4'd1);
        add(0,0, 1,1,0, 2'd1,6'h0A,4'd1);
        add(0,0, 0,1,0, 2'd1,6'h0A,4'd2);
        add(0,0, 1,1,0, 2'd2,6'h00,4'd2);
        add(0,0, 0,1,0, 2'd2,6'h00,4'd3);
        add(0,0, 1,1,1, 2'd3,6'h30,4'd3);
        add(0,0, 0,0,0, 2'd3,6'h30,4'd3);
        for (int i = 0; i < vq.size(); i++) begin
            START = vq[i].start; STALL = vq[i].stall;
            #1;
            check($sformatf("vec%0d_valid", i),   32'(VALID),   32'(vq[i].valid));
            check($sformatf("vec%0d_busy", i),    32'(BUSY),    32'(vq[i].busy));
            check($sformatf("vec%0d_done", i),    32'(DONE),    32'(vq[i].done));
            check($sformatf("vec%0d_instr", i),   32'(INSTR),   32'(vq[i].instr));
            check($sformatf("vec%0d_operand", i), 32'(OPERAND), 32'(vq[i].operand));
            check($sformatf("vec%0d_pc", i),      32'(PC),      32'(vq[i].pc));
            next_cycle();
        end
        START = 1'b0; STALL = 1'b0;

        // JUMP 3 skips words 1 and 2.
        load_word(0, 8'hC3); load_word(3, 8'hF0);
        run_program("jump", 10, 0, halted);
        check("jump_halted", 32'(halted), 32'd1);
        check("jump_trace_len", 32'(trace.size()), 32'd2);
        if (trace.size() == 2) begin
            check("jump_trace0", 32'(trace[0]), 32'd0);
            check("jump_trace1", 32'(trace[1]), 32'd3);
        end

        // Endless loop with wrap via JUMP 0, reset mid-run, memory survives.
        for (int a = 0; a < 15; a++) load_word(a, 8'h00);
        load_word(15, 8'hC0);
        run_program("loop", 20, 0, halted);
        check("loop_no_halt", 32'(halted), 32'd0);
        check("loop_trace15", 32'(trace[15]), 32'd15);
        check("loop_trace16", 32'(trace[16]), 32'd0);
        apply_reset("loop_rst");
        run_program("loop2", 17, 1, halted);
        check("loop2_trace16", 32'(trace[16]), 32'd0);
        apply_reset("loop2_rst");

        // Loads and START while busy are dropped.
        load_word(0, 8'h20); load_word(1, 8'hF0);
        run_program("busyload", 10, 2, halted);
        check("busyload_halted", 32'(halted), 32'd1);
        run_program("busyload_rerun", 10, 0, halted);
        check("busyload_rerun_halted", 32'(halted), 32'd1);

        // START together with LOAD_EN in IDLE: write happens, no start.
        START = 1'b1; LOAD_EN = 1'b1; LOAD_ADDR = 4'd1; LOAD_DATA = 8'hF5;
        #1;
        check("startload_busy0", 32'(BUSY), 32'd0);
        next_cycle();
        START = 1'b0; LOAD_EN = 1'b0;
        ref_mem[1] = 8'hF5;
        check("startload_busy1", 32'(BUSY), 32'd0);
        next_cycle();
        check("startload_busy2", 32'(BUSY), 32'd0);
        run_program("startload_run", 10, 0, halted);
        check("startload_trace_len", 32'(trace.size()), 32'd2);

        // Random programs with random stalls and ignored START/LOAD noise.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) load_word(a, 8'($urandom));
            run_program($sformatf("rand%0d", r), 30, 1, halted);
            if (!halted) apply_reset($sformatf("rand%0d_rst", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch and sequencing stage that sits directly upstream of the `Controller` decoder. It holds a small loadable program memory and steps a program counter through it. Each instruction is issued as a 2-bit opcode on `INSTR`, together with its operand, and held stable for the decoder to register. Jumps, halt, stall and single-run start/stop are handled here, so the decoder stays purely an opcode-to-control-word map.

## Interface
Parameters:
- `AW`, 4, program-memory address width (depth = 2^AW words)
- `DW`, 8, instruction word width (opcode = bits [DW-1:DW-2], operand = bits [DW-3:0])

Ports:
- `CLK` in 1: sole clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `LOAD_EN` in 1: write `LOAD_DATA` to `mem[LOAD_ADDR]`; honoured only in IDLE
- `LOAD_ADDR` in AW: program-memory write address
- `LOAD_DATA` in DW: program-memory write data
- `START` in 1: begin execution at address 0; honoured only in IDLE when `LOAD_EN`=0
- `STALL` in 1: downstream back-pressure; freezes ISSUE
- `INSTR` out 2: opcode to decoder
- `OPERAND` out DW-2: operand field of the issued instruction
- `PC` out AW: address of the instruction currently in IR
- `VALID` out 1: `INSTR`/`OPERAND` are a fresh issue this cycle
- `BUSY` out 1: state is not IDLE
- `DONE` out 1: one-cycle pulse when HALT retires

## Operation
- FSM states:
  - IDLE
    - `START` → FETCH, with PC←0.
  - FETCH
    - IR←`mem[PC]`.
    - → ISSUE.
  - ISSUE
    - `VALID`=1.
    - If `STALL`=1, remain in ISSUE with all outputs frozen and `VALID` kept high.
    - Otherwise, retire the instruction by opcode:
      - 00, 01, 10: PC←PC+1 (mod 2^AW, wraps 15→0), → FETCH.
      - 11 with operand[5:4]≠2'b11 (JUMP): PC←operand[AW-1:0], → FETCH.
      - 11 with operand[5:4]=2'b11 (HALT): `DONE`=1 for that cycle, → IDLE, PC unchanged.
- `INSTR`/`OPERAND` are driven from IR and hold their last value in IDLE and FETCH. Downstream must qualify them with `VALID`.
- Memory:
  - One write port and one read port.
  - A load and a fetch never coincide, because loads are accepted only in IDLE.
  - `LOAD_EN` outside IDLE is dropped silently.
- `START` outside IDLE is ignored. `START` and `LOAD_EN` together in IDLE: the load is performed and the start is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `PC`=0, IR=0, so `INSTR`=2'b00 and `OPERAND`=0.
  - `VALID`=0, `BUSY`=0, `DONE`=0.
  - Program memory is not reset; its contents survive `RST`.
- Start latency: `START` sampled high at edge n → FETCH during cycle n+1 → `VALID`=1 during cycle n+2.
- Issue rate, unstalled: one instruction per 2 cycles. `VALID` is high in alternate cycles.
- The decoder registers `SIGNAL` at the edge that ends an ISSUE cycle. Its output therefore lags `VALID` by one cycle.
- `STALL`:
  - Sampled in ISSUE only; ignored in other states.
  - A stall of k cycles extends ISSUE by exactly k cycles.
- JUMP to the current address is legal: it re-fetches the same word, giving an infinite loop until `RST`.
- `DONE` is asserted in the HALT retire cycle, while `BUSY`=1. `BUSY` falls the following cycle.
- `RST` mid-run: all outputs return to reset values immediately (asynchronously). Any partially issued instruction is discarded.

## Structure
- Shared package:
  - Opcode constants (`OP_0`..`OP_3`).
  - HALT operand-prefix constant 2'b11.
  - FSM state encoding {IDLE, FETCH, ISSUE}.
  - `AW`/`DW` defaults, reused by the decoder testbench.
- One natural sub-module: `prog_mem`, a 2^AW×DW register array with a synchronous write port and a combinational read port, no reset.
- Top level holds PC, IR, FSM and the output registers. Total 150–250 lines.

## Test plan
- Load mem[0..3]={8'h05,8'h4A,8'h80,8'hF0}, pulse `START` → `VALID` in cycles 2,4,6,8 with `INSTR`=00,01,10,11 and `PC`=0,1,2,3; `DONE` pulse in cycle 8; `BUSY` low in cycle 9.
- mem[0]=8'hC3 (JUMP 3), mem[3]=8'hF0 → issue order PC 0, 3; `DONE` after the second issue; mem[1],mem[2] are never issued.
- Hold `STALL`=1 for 3 cycles during the first ISSUE → `VALID` high for 4 consecutive cycles with stable `INSTR`/`PC`; next issue follows 2 cycles later.
- Fill all 16 words with 8'h00 except mem[15]=8'hC0 (JUMP 0) → PC sequence 0..15 then back to 0; no `DONE`. Assert `RST` mid-run → `BUSY`=0, `PC`=0, `VALID`=0 in the same cycle; memory still reads back the same program on a subsequent run.
- Apply `LOAD_EN`=1 to addr 0 with data 8'hFF while `BUSY`=1 → mem[0] unchanged after halt. `START` and `LOAD_EN` together in IDLE → write occurs and `BUSY` stays 0.
- Pulse `START` during ISSUE → no restart; PC continues its normal sequence.
